// File: rtl/mips_pkg.sv
// Shared definitions for the execute-stage multicycle units.
// Divider state encoding and iteration count.
package mips_pkg;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_t;

    localparam int DIV_ITERS = 32;

endpackage

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, MIPS32 DIV/DIVU semantics.
// One quotient bit per cycle on magnitudes, sign fixed on the last step.
module seq_divider
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             OP_div,
    input  logic             OP_divu,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Stall
);

    localparam int CW = $clog2(DIV_ITERS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_ITERS - 1);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic [WIDTH-1:0] dsh_q, dsh_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic             start;
    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] q_bits;
    logic [WIDTH-1:0] r_bits;

    assign start = OP_div | OP_divu;
    assign sgn   = OP_div;
    assign a_neg = sgn & Dividend[WIDTH-1];
    assign b_neg = sgn & Divisor[WIDTH-1];

    // Partial remainder stays below the divisor, so the 33-bit sign is exact.
    assign shifted = {prem_q, dsh_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign qbit    = ~trial[WIDTH];
    assign q_bits  = {dsh_q[WIDTH-2:0], qbit};
    assign r_bits  = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        dsh_d   = dsh_q;
        prem_d  = prem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    state_d = DIV_BUSY;
                    cnt_d   = CNT_LAST;
                    neg_q_d = a_neg ^ b_neg;
                    neg_r_d = a_neg;
                    dsh_d   = a_neg ? -Dividend : Dividend;
                    dvs_d   = b_neg ? -Divisor : Divisor;
                    prem_d  = '0;
                end
            end
            DIV_BUSY: begin
                dsh_d  = q_bits;
                prem_d = r_bits;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DIV_IDLE;
                    quo_d   = neg_q_q ? -q_bits : q_bits;
                    rem_d   = neg_r_q ? -r_bits : r_bits;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            dsh_q   <= '0;
            prem_q  <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            dsh_q   <= dsh_d;
            prem_q  <= prem_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    assign Stall     = (state_q == DIV_BUSY);
    assign Quotient  = quo_q;
    assign Remainder = rem_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider.
// Reference model uses plain integer division with MIPS corner cases.
module tb_seq_divider;

    logic        clock;
    logic        reset;
    logic        OP_div;
    logic        OP_divu;
    logic [31:0] Dividend;
    logic [31:0] Divisor;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic        Stall;

    int checks;
    int failures;
    logic [31:0] last_q;
    logic [31:0] last_r;

    seq_divider #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .OP_div    (OP_div),
        .OP_divu   (OP_divu),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Stall     (Stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void ref_div(input bit sgn, input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] q,
                                    output logic [31:0] r);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            r = a;
            q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    // Runs one division started at the next rising edge; checks latency,
    // hold of the previous result while busy, and the final values.
    task automatic do_div(input bit sgn, input bit both,
                          input logic [31:0] a, input logic [31:0] b,
                          input int poke_at, input string tag);
        logic [31:0] eq;
        logic [31:0] er;
        int cyc;
        bit held;
        cyc = 0;
        held = 1'b1;
        ref_div(sgn | both, a, b, eq, er);
        OP_div   = sgn | both;
        OP_divu  = !sgn | both;
        Dividend = a;
        Divisor  = b;
        @(posedge clock);
        #1;
        OP_div   = 1'b0;
        OP_divu  = 1'b0;
        Dividend = $urandom;
        Divisor  = $urandom;
        while (cyc < 100) begin
            @(negedge clock);
            if (!Stall) break;
            cyc++;
            if (Quotient !== last_q || Remainder !== last_r) held = 1'b0;
            if (cyc == poke_at) begin
                OP_divu  = 1'b1;
                Dividend = 32'd9;
                Divisor  = 32'd3;
            end else begin
                OP_divu = 1'b0;
            end
        end
        OP_divu = 1'b0;
        checks++;
        if (cyc !== 32) begin
            failures++;
            $display("FAIL %s stall_cycles got=%0d exp=32", tag, cyc);
        end
        checks++;
        if (!held) begin
            failures++;
            $display("FAIL %s hold_during_busy changed exp q=%h r=%h",
                     tag, last_q, last_r);
        end
        checks++;
        if (Quotient !== eq || Remainder !== er) begin
            failures++;
            $display("FAIL %s result a=%h b=%h s=%0d got q=%h r=%h exp q=%h r=%h",
                     tag, a, b, sgn | both, Quotient, Remainder, eq, er);
        end
        last_q = eq;
        last_r = er;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        OP_div   = 1'b0;
        OP_divu  = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        repeat (2) @(negedge clock);
        checks++;
        if (Stall !== 1'b0 || Quotient !== 32'd0 || Remainder !== 32'd0) begin
            failures++;
            $display("FAIL reset_state got s=%b q=%h r=%h exp 0 0 0",
                     Stall, Quotient, Remainder);
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (Stall !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset stall got=%b exp=0", Stall);
        end
        last_q = '0;
        last_r = '0;
    endtask

    task automatic test_directed();
        do_div(1'b0, 1'b0, 32'd100, 32'd7, -1, "divu_100_7");
        do_div(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, -1, "div_m7_2");
        do_div(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, -1, "div_7_m2");
        do_div(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
        do_div(1'b0, 1'b0, 32'h1234_5678, 32'd0, -1, "divu_by0");
        do_div(1'b1, 1'b0, 32'h8765_4321, 32'd0, -1, "div_neg_by0");
        do_div(1'b1, 1'b0, 32'd55, 32'd0, -1, "div_pos_by0");
        do_div(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, -1, "divu_max_1");
    endtask

    task automatic test_ignore_and_back_to_back();
        @(negedge clock);
        do_div(1'b0, 1'b0, 32'd100, 32'd7, 10, "ignore_busy_op");
        do_div(1'b0, 1'b0, 32'd9, 32'd3, -1, "back_to_back");
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        OP_divu  = 1'b1;
        Dividend = 32'd100;
        Divisor  = 32'd7;
        @(negedge clock);
        OP_divu = 1'b0;
        repeat (14) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (Stall !== 1'b0 || Quotient !== 32'd0 || Remainder !== 32'd0) begin
            failures++;
            $display("FAIL async_reset got s=%b q=%h r=%h exp 0 0 0",
                     Stall, Quotient, Remainder);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        checks++;
        if (Stall !== 1'b0 || Quotient !== 32'd0) begin
            failures++;
            $display("FAIL post_reset_idle got s=%b q=%h exp s=0 q=0",
                     Stall, Quotient);
        end
        last_q = '0;
        last_r = '0;
    endtask

    task automatic test_both_ops();
        @(negedge clock);
        do_div(1'b0, 1'b1, 32'hFFFF_FFF7, 32'd4, -1, "both_ops");
    endtask

    task automatic test_random();
        logic [31:0] edges [6];
        logic [31:0] a;
        logic [31:0] b;
        edges[0] = 32'h0000_0000;
        edges[1] = 32'h0000_0001;
        edges[2] = 32'hFFFF_FFFF;
        edges[3] = 32'h8000_0000;
        edges[4] = 32'h7FFF_FFFF;
        edges[5] = 32'hFFFF_FFFE;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            case ($urandom_range(0, 3))
                0: b = edges[$urandom_range(0, 5)];
                1: b = $urandom_range(1, 300);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1'b1) @(negedge clock);
            do_div(1'($urandom_range(0, 1)), 1'b0, a, b, -1, "random");
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        last_q   = '0;
        last_r   = '0;
        test_reset();
        test_directed();
        test_ignore_and_back_to_back();
        test_async_reset();
        test_both_ops();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
